// File: rtl/prf_free_list.sv
// Circular free list of physical register tags: up to WAYS grants per cycle, retirement refill,
// rollback to the committed head on exception. Define FREELIST_DEBUG_EN for debug ports and overflow flag.
module prf_free_list #(
    parameter  int WAYS  = 2,
    parameter  int PRF   = 64,
    parameter  int ARF   = 32,
    localparam int PW    = $clog2(PRF),
    localparam int DEPTH = PRF - ARF,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               except,
    input  logic [WAYS-1:0]    alloc_req,
    output logic [WAYS*PW-1:0] alloc_idx,
    output logic [WAYS-1:0]    alloc_valid,
    input  logic [WAYS-1:0]    retire_en,
    input  logic [WAYS*PW-1:0] retire_old_idx,
    output logic [CW-1:0]      free_count,
    output logic               empty
`ifdef FREELIST_DEBUG_EN
    ,
    output logic [DEPTH-1:0][PW-1:0] fl_entries_out,
    output logic                     fl_overflow
`endif
);

    localparam int              IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW:0]     DEPTH_W = (IW + 1)'(DEPTH);

    typedef struct packed {
        logic          wrap;
        logic [IW-1:0] idx;
    } ptr_t;

    // Advance a pointer by n (n <= DEPTH), flipping the wrap bit when the index passes DEPTH-1.
    function automatic ptr_t ptr_add(input ptr_t p, input logic [CW-1:0] n);
        logic [IW:0] sum;
        ptr_t        r;
        sum = {1'b0, p.idx} + (IW + 1)'(n);
        if (sum >= DEPTH_W) begin
            r.wrap = ~p.wrap;
            r.idx  = IW'(sum - DEPTH_W);
        end else begin
            r.wrap = p.wrap;
            r.idx  = sum[IW-1:0];
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] ptr_dist(input ptr_t a, input ptr_t b);
        if (a.wrap == b.wrap) return CW'(a.idx) - CW'(b.idx);
        return CW'(DEPTH) + CW'(a.idx) - CW'(b.idx);
    endfunction

    logic [PW-1:0]           entries [DEPTH];
    ptr_t                    head, tail, retire_head;
    ptr_t                    head_next, tail_next, retire_head_next;
    logic [CW-1:0]           grants, retires, free_count_next;
    logic [WAYS-1:0][IW-1:0] wr_addr;

    // Grants are compacted over requesting lanes and stop once the running request count exceeds free_count.
    always_comb begin
        logic [CW-1:0] n_req;
        ptr_t          rd_ptr;
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        alloc_idx   = '0;
        alloc_valid = '0;
        grants      = '0;
        n_req       = '0;
        rd_ptr      = head;
        for (int i = 0; i < WAYS; i++) begin
            if (alloc_req[i]) begin
                n_req = n_req + CW'(1);
                if (reset && !except && (n_req <= free_count)) begin
                    rd_ptr                = ptr_add(head, n_req - CW'(1));
                    alloc_valid[i]        = 1'b1;
                    alloc_idx[i*PW +: PW] = entries[rd_ptr.idx];
                    grants                = grants + CW'(1);
                end
            end
        end
    end

    always_comb begin
        ptr_t wr_ptr;
        wr_ptr  = tail;
        retires = '0;
        for (int i = 0; i < WAYS; i++) begin
            wr_addr[i] = wr_ptr.idx;
            if (retire_en[i]) begin
                wr_ptr  = ptr_add(wr_ptr, CW'(1));
                retires = retires + CW'(1);
            end
        end
        tail_next        = wr_ptr;
        retire_head_next = ptr_add(retire_head, retires);
        // Rollback lands on the committed head after this cycle's retirements are counted.
        head_next        = except ? retire_head_next : ptr_add(head, grants);
        free_count_next  = except ? ptr_dist(tail_next, retire_head_next)
                                  : free_count - grants + retires;
    end

    // NOTE: the tag array is reset on purpose: its initial contents are architecturally visible tags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) entries[k] <= PW'(ARF + k);
            head        <= '0;
            retire_head <= '0;
            tail        <= {1'b1, {IW{1'b0}}};
            free_count  <= CW'(DEPTH);
            empty       <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
            for (int i = 0; i < WAYS; i++) begin
                if (retire_en[i]) entries[wr_addr[i]] <= retire_old_idx[i*PW +: PW];
            end
            head        <= head_next;
            tail        <= tail_next;
            retire_head <= retire_head_next;
            free_count  <= free_count_next;
            empty       <= (free_count_next == '0);
        end
    end

`ifdef FREELIST_DEBUG_EN
    always_comb begin
        for (int k = 0; k < DEPTH; k++) fl_entries_out[k] = entries[k];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fl_overflow <= 1'b0;
        end else begin
            if ((|retire_en) && (int'(free_count) + int'(retires) > DEPTH)) fl_overflow <= 1'b1;
            if (except) $display("prf_free_list except: head=%0d free_count=%0d", head.idx, free_count);
        end
    end
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// Directed bench for prf_free_list (WAYS=2, PRF=64, ARF=32): reset-state vectors, drain/refill,
// last-entry grant, exception rollback with same-cycle retirement, and asynchronous reset mid-drain.
module tb_prf_free_list;

    localparam int WAYS = 2;
    localparam int PW   = 6;
    localparam int CW   = 6;

    logic               clock;
    logic               reset;
    logic               except;
    logic [WAYS-1:0]    alloc_req;
    logic [WAYS*PW-1:0] alloc_idx;
    logic [WAYS-1:0]    alloc_valid;
    logic [WAYS-1:0]    retire_en;
    logic [WAYS*PW-1:0] retire_old_idx;
    logic [CW-1:0]      free_count;
    logic               empty;

    int n_checks = 0;
    int n_fail   = 0;

    prf_free_list #(.WAYS(WAYS), .PRF(64), .ARF(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .except         (except),
        .alloc_req      (alloc_req),
        .alloc_idx      (alloc_idx),
        .alloc_valid    (alloc_valid),
        .retire_en      (retire_en),
        .retire_old_idx (retire_old_idx),
        .free_count     (free_count),
        .empty          (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] req;
        logic       exc;
        logic [1:0] ren;
        int         o0, o1;
        logic [1:0] ev;
        int         ei0, ei1, efc;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle at the falling edge, check the combinational grant, then the registered count.
    task automatic step(input string tag, input logic [1:0] req, input logic exc, input logic [1:0] ren,
                        input int o0, input int o1, input logic [1:0] ev, input int ei0, input int ei1,
                        input int efc);
        @(negedge clock);
        alloc_req      = req;
        except         = exc;
        retire_en      = ren;
        retire_old_idx = {PW'(o1), PW'(o0)};
        #1;
        check({tag, ".valid"}, int'(alloc_valid), int'(ev));
        check({tag, ".idx0"}, int'(alloc_idx[PW-1:0]), ei0);
        check({tag, ".idx1"}, int'(alloc_idx[2*PW-1:PW]), ei1);
        @(posedge clock);
        #1;
        check({tag, ".free_count"}, int'(free_count), efc);
        check({tag, ".empty"}, int'(empty), int'(efc == 0));
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        except         = 1'b0;
        alloc_req      = '0;
        retire_en      = '0;
        retire_old_idx = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("reset.free_count", int'(free_count), 32);
        check("reset.empty", int'(empty), 0);
        check("reset.valid", int'(alloc_valid), 0);
    endtask

    initial begin
        //          req    exc   ren    o0 o1 ev     ei0 ei1 efc
        vecs[0] = '{2'b11, 1'b0, 2'b00, 0, 0, 2'b11, 32, 33, 30};
        vecs[1] = '{2'b10, 1'b0, 2'b00, 0, 0, 2'b10, 0,  34, 29};
        vecs[2] = '{2'b01, 1'b0, 2'b00, 0, 0, 2'b01, 35, 0,  28};
        vecs[3] = '{2'b00, 1'b0, 2'b01, 1, 0, 2'b00, 0,  0,  29};
        vecs[4] = '{2'b11, 1'b1, 2'b00, 0, 0, 2'b00, 0,  0,  32};
        vecs[5] = '{2'b11, 1'b0, 2'b00, 0, 0, 2'b11, 33, 34, 30};

        do_reset();
        for (int v = 0; v < 6; v++) begin
            step($sformatf("vec%0d", v), vecs[v].req, vecs[v].exc, vecs[v].ren, vecs[v].o0, vecs[v].o1,
                 vecs[v].ev, vecs[v].ei0, vecs[v].ei1, vecs[v].efc);
        end

        // Drain the whole list two tags per cycle, then refill from retirement.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step($sformatf("drain%0d", k), 2'b11, 1'b0, 2'b00, 0, 0, 2'b11, 32 + 2*k, 33 + 2*k, 30 - 2*k);
        end
        step("empty_retire", 2'b11, 1'b0, 2'b01, 5, 0, 2'b00, 0, 0, 1);
        step("refill_grant", 2'b01, 1'b0, 2'b00, 0, 0, 2'b01, 5, 0, 0);
        step("set_one", 2'b00, 1'b0, 2'b01, 9, 0, 2'b00, 0, 0, 1);
        step("last_entry", 2'b11, 1'b0, 2'b01, 7, 0, 2'b01, 9, 0, 1);
        step("after_last", 2'b11, 1'b0, 2'b00, 0, 0, 2'b01, 7, 0, 0);
        step("dual_retire", 2'b00, 1'b0, 2'b11, 12, 13, 2'b00, 0, 0, 2);
        step("dual_grant", 2'b11, 1'b0, 2'b00, 0, 0, 2'b11, 12, 13, 0);
        step("exc_with_retire", 2'b11, 1'b1, 2'b01, 20, 0, 2'b00, 0, 0, 32);
        step("post_rollback", 2'b11, 1'b0, 2'b00, 0, 0, 2'b11, 38, 39, 30);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        step("pre_rst0", 2'b11, 1'b0, 2'b00, 0, 0, 2'b11, 32, 33, 30);
        step("pre_rst1", 2'b11, 1'b0, 2'b00, 0, 0, 2'b11, 34, 35, 28);
        @(negedge clock);
        alloc_req = 2'b11;
        retire_en = 2'b00;
        except    = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst.free_count", int'(free_count), 32);
        check("async_rst.valid", int'(alloc_valid), 0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("post_rst.valid", int'(alloc_valid), 3);
        check("post_rst.idx0", int'(alloc_idx[PW-1:0]), 32);
        check("post_rst.idx1", int'(alloc_idx[2*PW-1:PW]), 33);
        @(posedge clock);
        #1;
        check("post_rst.free_count", int'(free_count), 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
